node_sequencer: RTL and testbench

- Control stage directly upstream of the neural-network node.
- Steps one node through a full dot-product for each neuron in a layer: clears the accumulator, walks the input/coefficient index, holds the result, then hands the activated output downstream.
- Time-multiplexes a single node across NUM_NODES neurons by selecting the coefficient bank with node_idx.

---
 rtl/nn_pkg.sv | 19 +
 rtl/flex_counter.sv | 32 +++
 rtl/node_sequencer.sv | 141 ++++++++++++++
 tb/tb_node_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-network node datapath and its sequencer.
package nn_pkg;

  localparam int unsigned ImageSizeDef = 64;
  localparam int unsigned NumNodesDef  = 16;
  localparam int unsigned WordW        = 16;

  typedef logic [WordW-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SETTLE,
    OUTPUT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with programmable rollover value, synchronous clear and count enable.
module flex_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_rollover,
  output logic [W-1:0] o_count,
  output logic         o_at_max
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == i_rollover);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_max ? '0 : r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/node_sequencer.sv
// Steps one time-multiplexed node through a dot-product per neuron and hands each
// activated result downstream with a valid/ready handshake.
module node_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE = ImageSizeDef,
  parameter int unsigned CNT_W      = 7,
  parameter int unsigned NUM_NODES  = NumNodesDef,
  parameter int unsigned NODE_W     = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              layer_start,
  output logic              layer_busy,
  output logic              layer_done,
  output logic              reset_acc,
  output logic              acc_hold,
  output logic [CNT_W-1:0]  cnt_val,
  output logic [NODE_W-1:0] node_idx,
  input  word_t             node_out,
  output logic              res_valid,
  input  logic              res_ready,
  output word_t             res_data,
  output logic [NODE_W-1:0] res_idx
);

  localparam logic [CNT_W-1:0]  CntMax  = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [NODE_W-1:0] NodeMax = NODE_W'(NUM_NODES - 1);

  seq_state_t        r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_reset_acc;
  logic              r_acc_hold;
  logic              r_res_valid;
  word_t             r_res_data;
  logic [NODE_W-1:0] r_res_idx;

  logic [CNT_W-1:0]  w_cnt;
  logic              w_cnt_last;
  logic [NODE_W-1:0] w_node_idx;
  logic              w_node_last;
  logic              w_handshake;

  assign w_handshake = (r_state == OUTPUT) && r_res_valid && res_ready;

  // Index counter parks at its last value on leaving ACCUM and is zeroed during SETTLE.
  flex_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_clear    (r_state == SETTLE),
    .i_en       ((r_state == ACCUM) && !w_cnt_last),
    .i_rollover (CntMax),
    .o_count    (w_cnt),
    .o_at_max   (w_cnt_last)
  );

  // Neuron index returns to zero only via DONE, never by natural rollover.
  flex_counter #(
    .W (NODE_W)
  ) u_node (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_clear    (r_state == DONE),
    .i_en       (w_handshake && !w_node_last),
    .i_rollover (NodeMax),
    .o_count    (w_node_idx),
    .o_at_max   (w_node_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_reset_acc <= 1'b0;
      r_acc_hold  <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (layer_start) begin
            r_state     <= CLEAR;
            r_busy      <= 1'b1;
            r_reset_acc <= 1'b1;
          end
        end
        CLEAR: begin
          r_state     <= ACCUM;
          r_reset_acc <= 1'b0;
          r_acc_hold  <= 1'b0;
        end
        ACCUM: begin
          if (w_cnt_last) begin
            r_state    <= SETTLE;
            r_acc_hold <= 1'b1;
          end
        end
        SETTLE: begin
          r_state     <= OUTPUT;
          r_res_valid <= 1'b1;
          r_res_data  <= node_out;
          r_res_idx   <= w_node_idx;
        end
        OUTPUT: begin
          if (w_handshake) begin
            r_res_valid <= 1'b0;
            if (w_node_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= CLEAR;
              r_reset_acc <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign layer_busy = r_busy;
  assign layer_done = r_done;
  assign reset_acc  = r_reset_acc;
  assign acc_hold   = r_acc_hold;
  assign cnt_val    = w_cnt;
  assign node_idx   = w_node_idx;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_idx    = r_res_idx;

endmodule

// File: tb/tb_node_sequencer.sv
// Self-checking bench for node_sequencer: cycle model plus directed timing checks.
module tb_node_sequencer;

  localparam int IMG = 64;
  localparam int NN  = 16;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        layer_start;
  logic        layer_busy;
  logic        layer_done;
  logic        reset_acc;
  logic        acc_hold;
  logic [6:0]  cnt_val;
  logic [3:0]  node_idx;
  logic [15:0] node_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_idx;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  // Node stub: activated output is the neuron index replicated in both bytes.
  assign node_out = 16'(node_idx) * 16'h0101;

  node_sequencer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .layer_start (layer_start),
    .layer_busy  (layer_busy),
    .layer_done  (layer_done),
    .reset_acc   (reset_acc),
    .acc_hold    (acc_hold),
    .cnt_val     (cnt_val),
    .node_idx    (node_idx),
    .node_out    (node_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_idx     (res_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the neuron began (0 = clear, 1..IMG = accumulate,
  // IMG+1 = settle, beyond = waiting for the consumer).
  logic        m_busy, m_done, m_rv;
  int          m_t, m_node;
  logic [15:0] m_rd;
  int          m_ri;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_t <= 0; m_node <= 0;
      m_rv <= 1'b0; m_rd <= '0; m_ri <= 0;
    end else if (!m_busy) begin
      if (layer_start) begin
        m_busy <= 1'b1; m_t <= 0; m_node <= 0;
      end
    end else if (m_done) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_node <= 0;
    end else if (m_t <= IMG) begin
      m_t <= m_t + 1;
    end else if (m_t == IMG + 1) begin
      m_rv <= 1'b1; m_rd <= 16'(m_node * 257); m_ri <= m_node; m_t <= m_t + 1;
    end else if (res_ready) begin
      m_rv <= 1'b0;
      if (m_node == NN - 1) m_done <= 1'b1;
      else begin
        m_node <= m_node + 1; m_t <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic in_neuron;
      in_neuron = m_busy && !m_done;
      chk("cmp_busy", 32'(layer_busy), 32'(m_busy));
      chk("cmp_done", 32'(layer_done), 32'(m_done));
      chk("cmp_reset_acc", 32'(reset_acc), 32'(in_neuron && m_t == 0));
      chk("cmp_acc_hold", 32'(acc_hold), 32'(!(in_neuron && m_t >= 1 && m_t <= IMG)));
      chk("cmp_node_idx", 32'(node_idx), 32'(m_node));
      chk("cmp_res_valid", 32'(res_valid), 32'(m_rv));
      chk("cmp_res_data", 32'(res_data), 32'(m_rd));
      chk("cmp_res_idx", 32'(res_idx), 32'(m_ri));
      if (in_neuron && m_t <= IMG + 1)
        chk("cmp_cnt_val", 32'(cnt_val), 32'((m_t == 0) ? 0 : (m_t > IMG) ? IMG - 1 : m_t - 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int q_idx[$];
  int q_dat[$];

  // Runs one layer starting now; cycle n is the n-th cycle after the start edge.
  task automatic run_layer(input int stall_node, input bit inject, input int exp_done);
    int n = 1, first_rc = -1, first_rv = -1, done_n = -1, stall_cnt = 0;
    bit hs_prev = 1'b0;
    q_idx.delete();
    q_dat.delete();
    layer_start = 1'b1;
    tick();
    while (done_n < 0 && n < 4000) begin
      layer_start = 1'b0;
      res_ready   = 1'b1;
      if (reset_acc && first_rc < 0) first_rc = n;
      if (res_valid && first_rv < 0) first_rv = n;
      if (hs_prev) begin
        chk("bp_clear_next", 32'(reset_acc), 1);
        chk("bp_next_node", 32'(node_idx), 32'(stall_node + 1));
        hs_prev = 1'b0;
      end
      if (inject && !acc_hold && node_idx == 0 && cnt_val == 10) layer_start = 1'b1;
      if (res_valid && int'(res_idx) == stall_node && stall_cnt < 10) begin
        res_ready = 1'b0;
        stall_cnt++;
        chk("bp_data", 32'(res_data), 32'(stall_node * 257));
        chk("bp_idx", 32'(res_idx), 32'(stall_node));
        chk("bp_hold", 32'(acc_hold), 1);
      end else if (res_valid && int'(res_idx) == stall_node) begin
        hs_prev = 1'b1;
      end
      if (res_valid && res_ready) begin
        q_idx.push_back(int'(res_idx));
        q_dat.push_back(int'(res_data));
      end
      if (layer_done) begin
        done_n = n;
        if (inject) layer_start = 1'b1;
      end
      tick();
      n++;
    end
    layer_start = 1'b0;
    res_ready   = 1'b1;
    chk("first_reset_acc_cycle", 32'(first_rc), 1);
    chk("first_res_valid_cycle", 32'(first_rv), 67);
    chk("layer_done_cycle", 32'(done_n), 32'(exp_done));
    chk("result_count", 32'(q_idx.size()), 16);
    if (stall_node >= 0) chk("stall_cycles", 32'(stall_cnt), 10);
    for (int i = 0; i < q_idx.size(); i++) begin
      chk("result_idx", 32'(q_idx[i]), 32'(i));
      chk("result_data", 32'(q_dat[i]), 32'(i * 16'h0101));
    end
  endtask

  initial begin
    int k;
    n_rst       = 1'b0;
    layer_start = 1'b0;
    res_ready   = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(layer_busy), 0);
    chk("rst_done", 32'(layer_done), 0);
    chk("rst_reset_acc", 32'(reset_acc), 0);
    chk("rst_acc_hold", 32'(acc_hold), 1);
    chk("rst_cnt_val", 32'(cnt_val), 0);
    chk("rst_node_idx", 32'(node_idx), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    n_rst  = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Layer with stray starts mid-accumulate and in the DONE cycle.
    run_layer(-1, 1'b1, 1073);
    chk("start_in_done_ignored", 32'(layer_busy), 0);
    // Back-to-back with backpressure on neuron 3, then a plain back-to-back layer.
    run_layer(3, 1'b0, 1083);
    run_layer(-1, 1'b0, 1073);

    // Reset in the middle of accumulation.
    repeat (2) tick();
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    k = 0;
    while (!(cnt_val == 30 && !acc_hold) && k < 200) begin
      tick();
      k++;
    end
    chk("reach_cnt30", 32'(cnt_val), 30);
    #1 n_rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(layer_busy), 0);
    chk("midrst_done", 32'(layer_done), 0);
    chk("midrst_reset_acc", 32'(reset_acc), 0);
    chk("midrst_acc_hold", 32'(acc_hold), 1);
    chk("midrst_cnt_val", 32'(cnt_val), 0);
    chk("midrst_node_idx", 32'(node_idx), 0);
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_res_data", 32'(res_data), 0);
    chk("midrst_res_idx", 32'(res_idx), 0);
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    chk("post_rst_idle", 32'(layer_busy), 0);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    chk("restart_reset_acc", 32'(reset_acc), 1);
    chk("restart_node_idx", 32'(node_idx), 0);
    chk("restart_cnt_val", 32'(cnt_val), 0);
    repeat (5) tick();
    chk("restart_accum", 32'(cnt_val), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
